alu_sequencer: RTL and testbench

//  Command-driven controller that sequences the 8-bit ALU (operands R0/R1, fs, result R2, 4-bit flag).

---
 rtl/alu_sequencer_if.sv | 49 ++++
 rtl/alu_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command, response and ALU-drive bundle for alu_sequencer.
// slave is the sequencer side, master the command source / ALU side.
interface alu_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [1:0]    cmd_fs;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;
    logic [DW-1:0] cmd_imm;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_fs;
    logic [DW-1:0] alu_y;
    logic [3:0]    alu_flag;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [3:0]    flags;
    logic          busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_fs,
        input  cmd_rd, cmd_ra, cmd_rb, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_fs,
        input  alu_y, alu_flag,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output flags, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_fs,
        output cmd_rd, cmd_ra, cmd_rb, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_fs,
        output alu_y, alu_flag,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  flags, busy
    );
endinterface

// File: rtl/alu_sequencer.sv
// Command sequencer around an external 8-bit ALU: register file,
// operand/fs registers, write-back and a held valid/ready response.
module alu_sequencer #(
    parameter int DW       = 8,
    parameter int NREG     = 4,
    parameter int AW       = 2,
    parameter int ALU_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [1:0]    fs_q, fs_d;
    logic [DW-1:0] rsp_q, rsp_d;
    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        fs_d    = fs_q;
        rsp_d   = rsp_q;
        flags_d = flags_q;
        regs_d  = regs_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    unique case (bus.cmd_op)
                        OP_NOP: begin
                            rsp_d   = '0;
                            state_d = S_RESP;
                        end
                        OP_LDI: begin
                            regs_d[bus.cmd_rd] = bus.cmd_imm;
                            rsp_d   = bus.cmd_imm;
                            state_d = S_RESP;
                        end
                        // Operands are captured here, so rd==ra/rb sees the old value
                        OP_ALU: begin
                            a_d     = regs_q[bus.cmd_ra];
                            b_d     = regs_q[bus.cmd_rb];
                            fs_d    = bus.cmd_fs;
                            rd_d    = bus.cmd_rd;
                            cnt_d   = WAIT_INIT;
                            state_d = S_EXEC;
                        end
                        OP_RD: begin
                            rsp_d   = regs_q[bus.cmd_ra];
                            state_d = S_RESP;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    regs_d[rd_q] = bus.alu_y;
                    flags_d = bus.alu_flag;
                    rsp_d   = bus.alu_y;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fs_q    <= '0;
            rsp_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fs_q    <= fs_d;
            rsp_q   <= rsp_d;
            flags_q <= flags_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = rsp_q;
    assign bus.flags     = flags_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_fs    = fs_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Drives two sequencers (ALU_WAIT 0 and 3) with the same commands and
// checks them against a register/flag model plus a behavioural ALU.
module tb_alu_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [7:0] m_reg [4];
    logic [3:0] m_flags;

    alu_sequencer_if #(.DW(8), .AW(2)) b0 ();
    alu_sequencer_if #(.DW(8), .AW(2)) b3 ();

    alu_sequencer #(.DW(8), .NREG(4), .AW(2), .ALU_WAIT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    alu_sequencer #(.DW(8), .NREG(4), .AW(2), .ALU_WAIT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    // External ALU: 00 add, 01 sub, 10 and, 11 or; flag = {C, V, N, Z}
    function automatic logic [11:0] alu_fn(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [1:0] fs);
        int s;
        logic [7:0] y;
        logic c, v;
        case (fs)
            2'b00: s = int'(a) + int'(b);
            2'b01: s = int'(a) - int'(b);
            2'b10: s = int'(a & b);
            default: s = int'(a | b);
        endcase
        y = 8'(s);
        c = (s > 255) || (s < 0);
        v = 1'b0;
        if (fs == 2'b00) v = (a[7] == b[7]) && (y[7] != a[7]);
        if (fs == 2'b01) v = (a[7] != b[7]) && (y[7] != a[7]);
        return {c, v, y[7], (y == 8'h00), y};
    endfunction

    assign {b0.alu_flag, b0.alu_y} = alu_fn(b0.alu_a, b0.alu_b, b0.alu_fs);
    assign {b3.alu_flag, b3.alu_y} = alu_fn(b3.alu_a, b3.alu_b, b3.alu_fs);

    assign b3.cmd_valid = b0.cmd_valid;
    assign b3.cmd_op    = b0.cmd_op;
    assign b3.cmd_fs    = b0.cmd_fs;
    assign b3.cmd_rd    = b0.cmd_rd;
    assign b3.cmd_ra    = b0.cmd_ra;
    assign b3.cmd_rb    = b0.cmd_rb;
    assign b3.cmd_imm   = b0.cmd_imm;
    assign b3.rsp_ready = b0.rsp_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!(b0.cmd_ready && b3.cmd_ready) && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk("ready_timeout", 32'(g < 40), 32'd1);
    endtask

    task automatic drive(input logic [1:0] op, input logic [1:0] fs,
                         input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] imm);
        b0.cmd_op  = op;
        b0.cmd_fs  = fs;
        b0.cmd_rd  = rd;
        b0.cmd_ra  = ra;
        b0.cmd_rb  = rb;
        b0.cmd_imm = imm;
    endtask

    task automatic run(input logic [1:0] op, input logic [1:0] fs,
                       input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [7:0] imm);
        logic [7:0]  ea, eb, exp_d, d0, d3;
        logic [11:0] r;
        int l0, l3;
        ea = m_reg[ra];
        eb = m_reg[rb];
        exp_d = 8'h00;
        case (op)
            2'b01: begin exp_d = imm; m_reg[rd] = imm; end
            2'b10: begin
                r = alu_fn(ea, eb, fs);
                exp_d = r[7:0];
                m_reg[rd] = r[7:0];
                m_flags = r[11:8];
            end
            2'b11: exp_d = ea;
            default: exp_d = 8'h00;
        endcase
        wait_ready();
        drive(op, fs, rd, ra, rb, imm);
        b0.cmd_valid = 1'b1;
        @(posedge clk); #1;
        b0.cmd_valid = 1'b0;
        l0 = 0; l3 = 0; d0 = 8'h00; d3 = 8'h00;
        for (int k = 1; k <= 20 && (l0 == 0 || l3 == 0); k++) begin
            if (k == 1 && op == 2'b10) begin
                chk("alu_a0", 32'(b0.alu_a), 32'(ea));
                chk("alu_b0", 32'(b0.alu_b), 32'(eb));
                chk("alu_fs0", 32'(b0.alu_fs), 32'(fs));
                chk("alu_a3", 32'(b3.alu_a), 32'(ea));
                chk("alu_b3", 32'(b3.alu_b), 32'(eb));
                chk("busy3", 32'(b3.busy), 32'd1);
            end
            if (l0 == 0 && b0.rsp_valid) begin l0 = k; d0 = b0.rsp_data; end
            if (l3 == 0 && b3.rsp_valid) begin l3 = k; d3 = b3.rsp_data; end
            @(posedge clk); #1;
        end
        chk("lat0", 32'(l0), (op == 2'b10) ? 32'd2 : 32'd1);
        chk("lat3", 32'(l3), (op == 2'b10) ? 32'd5 : 32'd1);
        chk("data0", 32'(d0), 32'(exp_d));
        chk("data3", 32'(d3), 32'(exp_d));
        chk("flags0", 32'(b0.flags), 32'(m_flags));
        chk("flags3", 32'(b3.flags), 32'(m_flags));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_flags = 4'h0;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_rv0"}, 32'(b0.rsp_valid), 32'd0);
        chk({tag, "_rv3"}, 32'(b3.rsp_valid), 32'd0);
        chk({tag, "_cr0"}, 32'(b0.cmd_ready), 32'd1);
        chk({tag, "_cr3"}, 32'(b3.cmd_ready), 32'd1);
        chk({tag, "_fl0"}, 32'(b0.flags), 32'd0);
        chk({tag, "_fl3"}, 32'(b3.flags), 32'd0);
        chk({tag, "_rd3"}, 32'(b3.rsp_data), 32'd0);
        chk({tag, "_a3"}, 32'(b3.alu_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst = 1'b1;
        b0.cmd_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        drive(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_idle_reset("por");

        // Basic loads and readback
        run(2'b01, 2'b00, 2'd0, 2'd0, 2'd0, 8'h02);
        run(2'b01, 2'b00, 2'd1, 2'd0, 2'd0, 8'h01);
        run(2'b11, 2'b00, 2'd0, 2'd0, 2'd0, 8'h00);
        run(2'b10, 2'b10, 2'd2, 2'd0, 2'd1, 8'h00);
        run(2'b11, 2'b00, 2'd0, 2'd2, 2'd0, 8'h00);
        run(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 8'hAA);

        // Add with carry out
        run(2'b01, 2'b00, 2'd0, 2'd0, 2'd0, 8'h23);
        run(2'b01, 2'b00, 2'd1, 2'd0, 2'd0, 8'hFD);
        run(2'b10, 2'b00, 2'd2, 2'd0, 2'd1, 8'h00);

        // Hazard: rd == ra == rb
        run(2'b01, 2'b00, 2'd1, 2'd0, 2'd0, 8'h12);
        run(2'b10, 2'b01, 2'd1, 2'd1, 2'd1, 8'h00);
        run(2'b11, 2'b00, 2'd0, 2'd1, 2'd0, 8'h00);

        // Backpressure with a competing command held on the port
        wait_ready();
        b0.rsp_ready = 1'b0;
        drive(2'b01, 2'b00, 2'd3, 2'd0, 2'd0, 8'h5A);
        b0.cmd_valid = 1'b1;
        @(posedge clk); #1;
        m_reg[3] = 8'h5A;
        drive(2'b01, 2'b00, 2'd3, 2'd0, 2'd0, 8'hEE);
        for (int k = 0; k < 10; k++) begin
            chk("bp_rv0", 32'(b0.rsp_valid), 32'd1);
            chk("bp_rv3", 32'(b3.rsp_valid), 32'd1);
            chk("bp_data0", 32'(b0.rsp_data), 32'h5A);
            chk("bp_data3", 32'(b3.rsp_data), 32'h5A);
            chk("bp_cr0", 32'(b0.cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        b0.cmd_valid = 1'b0;
        b0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drop0", 32'(b0.rsp_valid), 32'd0);
        chk("bp_drop3", 32'(b3.rsp_valid), 32'd0);
        run(2'b11, 2'b00, 2'd0, 2'd3, 2'd0, 8'h00);

        // Randomized command stream
        for (int n = 0; n < 60; n++) begin
            run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 8'($urandom));
        end

        // Make flags non-zero, then reset while the slow instance is in EXEC
        run(2'b01, 2'b00, 2'd0, 2'd0, 2'd0, 8'h80);
        run(2'b10, 2'b00, 2'd1, 2'd0, 2'd0, 8'h00);
        wait_ready();
        drive(2'b10, 2'b00, 2'd2, 2'd0, 2'd1, 8'h00);
        b0.cmd_valid = 1'b1;
        @(posedge clk); #1;
        b0.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_busy3", 32'(b3.busy), 32'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_idle_reset("mid");
        for (int i = 0; i < 4; i++) begin
            run(2'b11, 2'b00, 2'd0, 2'(i), 2'd0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
